// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Optional feature: define MDU_ABORT_EN to add an Abort input that cancels an in-flight operation.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Hi_we,
  input  logic             Lo_we,
  input  logic [WIDTH-1:0] Wdata,
`ifdef MDU_ABORT_EN
  input  logic             Abort,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = WIDTH[CW-1:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic              div0_q, div0_d;
  logic [WIDTH-1:0]  a_raw_q, a_raw_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              abort_s;
  logic              signed_op_s;
  logic [WIDTH-1:0]  a_mag_s, b_mag_s;
  logic [WIDTH:0]    mul_sum_s;
  logic [WIDTH:0]    div_shift_s;
  logic [WIDTH+1:0]  div_diff_s;
  logic              div_ge_s;
  logic [2*WIDTH-1:0] prod_s;

`ifdef MDU_ABORT_EN
  assign abort_s = Abort;
`else
  assign abort_s = 1'b0;
`endif

  // Operand magnitudes: MULT/DIV work on |A|,|B| and fix signs at the end.
  assign signed_op_s = ~Op[0];
  assign a_mag_s = (signed_op_s && A[WIDTH-1]) ? neg_w(A) : A;
  assign b_mag_s = (signed_op_s && B[WIDTH-1]) ? neg_w(B) : B;

  assign mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_q};
  assign div_ge_s    = ~div_diff_s[WIDTH+1];
  assign prod_s      = neg_lo_q ? neg_2w({acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};

  // Next-state, datapath step and result write-back.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    a_raw_d  = a_raw_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d  = S_CALC;
          cnt_d    = {CW{1'b0}};
          is_div_d = Op[1];
          neg_lo_d = signed_op_s & (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_hi_d = signed_op_s & A[WIDTH-1];
          div0_d   = (B == {WIDTH{1'b0}});
          a_raw_d  = A;
          opnd_d   = Op[1] ? b_mag_s : a_mag_s;
          acc_lo_d = Op[1] ? a_mag_s : b_mag_s;
          acc_hi_d = {WIDTH{1'b0}};
        end else begin
          hi_d = Hi_we ? Wdata : hi_q;
          lo_d = Lo_we ? Wdata : lo_q;
        end
      end
      S_CALC: begin
        if (abort_s) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_STEP) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (is_div_q) begin
            acc_hi_d = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge_s};
          end else begin
            acc_hi_d = mul_sum_s[WIDTH:1];
            acc_lo_d = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (abort_s) begin
          done_d = 1'b0;
        end else begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_s[2*WIDTH-1:WIDTH];
            lo_d = prod_s[WIDTH-1:0];
          end else if (div0_q) begin
            hi_d = a_raw_q;
            lo_d = {WIDTH{1'b1}};
          end else begin
            hi_d = neg_hi_q ? neg_w(acc_hi_q) : acc_hi_q;
            lo_d = neg_lo_q ? neg_w(acc_lo_q) : acc_lo_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Busy rises one cycle after acceptance and drops with the return to IDLE.
    busy_d = (state_q != S_IDLE) && (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      a_raw_q  <= {WIDTH{1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      acc_hi_q <= {WIDTH{1'b0}};
      acc_lo_q <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      a_raw_q  <= a_raw_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule
